// File: rtl/flagger_pkg.sv
// Purpose: shared definitions for the pipelined ALU flagger (flag indices, funct7 codes, flags type).
// Latency: n/a (package only).
// Backpressure: n/a.
package flagger_pkg;

  // Bit positions inside the 4-bit flags vector.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_MSB   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;

  // funct7 selector bit: add vs subtract.
  localparam logic FUNCT7_ADD = 1'b0;
  localparam logic FUNCT7_SUB = 1'b1;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_compute_comb.sv
// Purpose: combinational flag/compare evaluation on the effective width (HALFSIZE for W ops, else WORDSIZE).
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to capture the outputs.
// Ports: a_i/b_i operands, r_i ALU result, funct7_i add/sub, word_op_i width select;
//        flags_o {carry, ovf, msb, zero}, lt_o signed a<b, ltu_o unsigned a<b.
module flag_compute_comb
  import flagger_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int HALFSIZE = 32
) (
  input  logic [WORDSIZE-1:0] a_i,
  input  logic [WORDSIZE-1:0] b_i,
  input  logic [WORDSIZE-1:0] r_i,
  input  logic                funct7_i,
  input  logic                word_op_i,
  output flags_t              flags_o,
  output logic                lt_o,
  output logic                ltu_o
);

  localparam int PADW = WORDSIZE - HALFSIZE;

  logic [WORDSIZE-1:0] a_m, b_m, r_m, na_m;
  logic                a_msb, b_msb, r_msb;
  logic                is_sub, ltu, add_carry, ovf;

  always_comb begin
    // Zero-extend the low half in word mode so the full-width compares
    // below naturally operate on E bits only.
    a_m   = word_op_i ? {{PADW{1'b0}}, a_i[HALFSIZE-1:0]}  : a_i;
    b_m   = word_op_i ? {{PADW{1'b0}}, b_i[HALFSIZE-1:0]}  : b_i;
    r_m   = word_op_i ? {{PADW{1'b0}}, r_i[HALFSIZE-1:0]}  : r_i;
    na_m  = word_op_i ? {{PADW{1'b0}}, ~a_i[HALFSIZE-1:0]} : ~a_i;
    a_msb = word_op_i ? a_i[HALFSIZE-1] : a_i[WORDSIZE-1];
    b_msb = word_op_i ? b_i[HALFSIZE-1] : b_i[WORDSIZE-1];
    r_msb = word_op_i ? r_i[HALFSIZE-1] : r_i[WORDSIZE-1];

    is_sub = (funct7_i == FUNCT7_SUB);
    ltu    = (a_m < b_m);

    // a + b carries out of E bits exactly when b exceeds (2^E-1 - a) = ~a.
    // Derived from operands only, so a wrong ALU result cannot corrupt it.
    add_carry = (b_m > na_m);

    if (is_sub) ovf = (a_msb != b_msb) && (r_msb != a_msb);
    else        ovf = (a_msb == b_msb) && (r_msb != a_msb);

    flags_o             = '0;
    flags_o[FLAG_ZERO]  = (r_m == '0);
    flags_o[FLAG_MSB]   = r_msb;
    flags_o[FLAG_OVF]   = ovf;
    flags_o[FLAG_CARRY] = is_sub ? ltu : add_carry;

    ltu_o = ltu;
    // Differing sign bits decide the signed compare; otherwise it matches unsigned.
    lt_o  = (a_msb != b_msb) ? a_msb : ltu;
  end

endmodule

// File: rtl/flagger_pipelined.sv
// Purpose: registered ALU flagger (zero/neg/ovf/carry, lt/ltu) with sticky overflow and optional event counter.
// Latency: 1 cycle; out_valid pulses for the cycle after an accepted input.
// Backpressure: stall freezes all state and drops the presented input (clear_sticky still acts).
// Ports: clk, reset (sync, active-high), in_valid, stall, input_a, input_b, result, funct7, word_op,
//        clear_sticky in; out_valid, flags, lt, ltu, sticky_ovf, ovf_count out.
// Build option: define FLAGGER_OVF_COUNTER_EN to implement the saturating ovf_count; otherwise it reads 0.
// WORDSIZE must be >= 33 and HALFSIZE < WORDSIZE.
module flagger_pipelined
  import flagger_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int HALFSIZE = 32,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                stall,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [WORDSIZE-1:0] result,
  input  logic                funct7,
  input  logic                word_op,
  input  logic                clear_sticky,
  output logic                out_valid,
  output logic [3:0]          flags,
  output logic                lt,
  output logic                ltu,
  output logic                sticky_ovf,
  output logic [CNT_W-1:0]    ovf_count
);

  flags_t flags_c, flags_q, flags_d;
  logic   lt_c, ltu_c;
  logic   lt_q, lt_d, ltu_q, ltu_d;
  logic   vld_q, vld_d;
  logic   sticky_q, sticky_d;
  logic   accept, ovf_event;

  flag_compute_comb #(
    .WORDSIZE (WORDSIZE),
    .HALFSIZE (HALFSIZE)
  ) u_comp (
    .a_i       (input_a),
    .b_i       (input_b),
    .r_i       (result),
    .funct7_i  (funct7),
    .word_op_i (word_op),
    .flags_o   (flags_c),
    .lt_o      (lt_c),
    .ltu_o     (ltu_c)
  );

  assign accept    = in_valid && !stall;
  assign ovf_event = accept && flags_c[FLAG_OVF];

  always_comb begin
    flags_d  = flags_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    vld_d    = accept;
    if (accept) begin
      flags_d = flags_c;
      lt_d    = lt_c;
      ltu_d   = ltu_c;
    end
    // Clear first, then apply a same-cycle overflow event on top of it.
    sticky_d = clear_sticky ? 1'b0 : sticky_q;
    if (ovf_event) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      vld_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef FLAGGER_OVF_COUNTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear_sticky ? '0 : cnt_q;
    // Saturate rather than wrap so a long run of overflows stays visible.
    if (ovf_event && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign out_valid  = vld_q;
  assign flags      = flags_q;
  assign lt         = lt_q;
  assign ltu        = ltu_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_flagger_pipelined.sv
module tb_flagger_pipelined;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int CW = 2;

`ifdef FLAGGER_OVF_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          stall;
  logic [W-1:0]  input_a, input_b, result;
  logic          funct7, word_op, clear_sticky;
  logic          out_valid;
  logic [3:0]    flags;
  logic          lt, ltu, sticky_ovf;
  logic [CW-1:0] ovf_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flagger_pipelined #(
    .WORDSIZE (W),
    .HALFSIZE (H),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .input_a      (input_a),
    .input_b      (input_b),
    .result       (result),
    .funct7       (funct7),
    .word_op      (word_op),
    .clear_sticky (clear_sticky),
    .out_valid    (out_valid),
    .flags        (flags),
    .lt           (lt),
    .ltu          (ltu),
    .sticky_ovf   (sticky_ovf),
    .ovf_count    (ovf_count)
  );

  function automatic logic [63:0] exp_cnt(input int v);
    return CNT_EN ? 64'(v) : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one set of inputs at a falling edge; return at the next falling
  // edge, i.e. half a cycle after the rising edge that sampled them.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                      input logic f7, input logic wop, input logic vld,
                      input logic stl, input logic clr, input logic rst);
    input_a      = a;
    input_b      = b;
    result       = r;
    funct7       = f7;
    word_op      = wop;
    in_valid     = vld;
    stall        = stl;
    clear_sticky = clr;
    reset        = rst;
    @(negedge clk);
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    @(negedge clk);
    // Reset with garbage inputs present
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_vld",    64'(out_valid),  64'd0);
    chk("rst_flags",  64'(flags),      64'd0);
    chk("rst_lt",     64'({lt, ltu}),  64'd0);
    chk("rst_sticky", 64'(sticky_ovf), 64'd0);
    chk("rst_cnt",    64'(ovf_count),  64'd0);

    // Basic add 5+2=7
    step(64'd5, 64'd2, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add_vld",   64'(out_valid), 64'd1);
    chk("add_flags", 64'(flags),     64'h0);
    chk("add_lt",    64'({lt, ltu}), 64'd0);
    idle();
    chk("add_vld_drop", 64'(out_valid), 64'd0);

    // Subtract to zero
    step(64'd2, 64'd2, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("subz_vld",   64'(out_valid), 64'd1);
    chk("subz_flags", 64'(flags),     64'h1);
    chk("subz_lt",    64'({lt, ltu}), 64'd0);

    // Signed overflow on add
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_flags",  64'(flags),      64'h6);
    chk("ovf_lt",     64'({lt, ltu}),  64'd0);
    chk("ovf_sticky", 64'(sticky_ovf), 64'd1);
    chk("ovf_cnt",    64'(ovf_count),  exp_cnt(1));
    idle();
    chk("hold_vld",   64'(out_valid), 64'd0);
    chk("hold_flags", 64'(flags),     64'h6);

    // Clear alone
    step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_sticky", 64'(sticky_ovf), 64'd0);
    chk("clr_cnt",    64'(ovf_count),  64'd0);
    chk("clr_flags",  64'(flags),      64'h6);

    // Word mode: low 32 bits overflow, full width does not
    step(64'h0000_0000_7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("word_flags", 64'(flags), 64'h6);
    step(64'h0000_0000_7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dword_flags", 64'(flags), 64'h0);
    // Word mode ignores upper garbage: -1 (low) < 1 signed, sub -> 0xFFFFFFFE
    step(64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0001, 64'hAAAA_AAAA_FFFF_FFFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("word_cmp_flags", 64'(flags),     64'h2);
    chk("word_cmp_lt",    64'({lt, ltu}), 64'b10);

    // Compare / borrow: -1 - 1
    step(ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cmp_flags", 64'(flags),     64'h2);
    chk("cmp_lt",    64'({lt, ltu}), 64'b10);

    // Add carry-out: -1 + 1 = 0 -> zero + carry
    step(ONES, 64'd1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("carry_flags", 64'(flags),     64'h9);
    chk("carry_lt",    64'({lt, ltu}), 64'b10);

    // Sub with borrow: 1 - 2 = -1
    step(64'd1, 64'd2, ONES, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("borrow_flags", 64'(flags),     64'hA);
    chk("borrow_lt",    64'({lt, ltu}), 64'b11);

    // Five overflows back to back: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++)
      step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt",    64'(ovf_count),  exp_cnt(3));
    chk("sat_sticky", 64'(sticky_ovf), 64'd1);

    // Clear and overflow in the same cycle: clear then count the event
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clrovf_sticky", 64'(sticky_ovf), 64'd1);
    chk("clrovf_cnt",    64'(ovf_count),  exp_cnt(1));

    // Stall with a valid zero-result input: dropped
    step(64'd2, 64'd2, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_vld",   64'(out_valid), 64'd0);
    chk("stall_flags", 64'(flags),     64'h6);
    // Stall with an overflowing input: counter frozen
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_cnt", 64'(ovf_count), exp_cnt(1));
    chk("stall_lt",  64'({lt, ltu}), 64'd0);
    // Clear still acts during stall
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("stall_clr_sticky", 64'(sticky_ovf), 64'd0);
    chk("stall_clr_cnt",    64'(ovf_count),  64'd0);

    // Load non-zero state, then reset while a valid input is present
    step(ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(MAXP, 64'd1, MINN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_sticky", 64'(sticky_ovf), 64'd1);
    step(ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mrst_vld",    64'(out_valid),  64'd0);
    chk("mrst_flags",  64'(flags),      64'd0);
    chk("mrst_lt",     64'({lt, ltu}),  64'd0);
    chk("mrst_sticky", 64'(sticky_ovf), 64'd0);
    chk("mrst_cnt",    64'(ovf_count),  64'd0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
